// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mult_pkg: shared types and defaults for the multiply/writeback |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package mult_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREG_DEF  = 16;

  typedef logic [3:0] reg_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WR_LO = 2'd2,
    WR_HI = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/decoder4to16.sv
`default_nettype none
// +----------------------------------------------------------------+
// | decoder4to16: one-hot register select with enable              |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module decoder4to16
  import mult_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic            en,
  input  reg_idx_t        idx,
  output logic [NREG-1:0] dec
);

  always_comb begin
    dec = '0;
    // Indices beyond the register count select nothing.
    if (en && (int'(idx) < NREG)) begin
      dec[idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------+
// | mult_writeback_unit: shift-add multiplier, two-word writeback  |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module mult_writeback_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG  = NREG_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [3:0]       destLo,
  input  logic [3:0]       destHi,
  output logic             busy,
  output logic             done,
  output logic             regWrite,
  output logic [NREG-1:0]  decOut,
  output logic [WIDTH-1:0] writeData
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      bit_cnt;
  reg_idx_t           dest_lo_q;
  reg_idx_t           dest_hi_q;
  logic               wr_active;
  reg_idx_t           sel_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      bit_cnt   <= '0;
      dest_lo_q <= '0;
      dest_hi_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand     <= {{WIDTH{1'b0}}, srcA};
            mplier    <= srcB;
            dest_lo_q <= destLo;
            dest_hi_q <= destHi;
            acc       <= '0;
            bit_cnt   <= '0;
            state     <= MUL;
          end
        end
        MUL: begin
          // LSB-first: add the aligned multiplicand when the current bit is set.
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            state <= WR_LO;
          end
        end
        WR_LO:   state <= WR_HI;
        WR_HI:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == WR_HI);
  assign wr_active = (state == WR_LO) || (state == WR_HI);
  assign regWrite  = wr_active;
  assign sel_idx   = (state == WR_HI) ? dest_hi_q : dest_lo_q;

  always_comb begin
    writeData = '0;
    case (state)
      WR_LO:   writeData = acc[WIDTH-1:0];
      WR_HI:   writeData = acc[2*WIDTH-1:WIDTH];
      default: writeData = '0;
    endcase
  end

  decoder4to16 #(
    .NREG (NREG)
  ) u_dec (
    .en  (wr_active),
    .idx (sel_idx),
    .dec (decOut)
  );

endmodule
`default_nettype wire
